// File: rtl/avg_pkg.sv
// Shared constants and types for the vector-generator state sequencer.
// Action codes are the nibble values stored in the 256x4 state PROM.
package avg_pkg;

    localparam int PROM_AW = 8;
    localparam int PROM_DW = 4;

    localparam logic [PROM_DW-1:0] ACT_LATCH0 = 4'd0;
    localparam logic [PROM_DW-1:0] ACT_LATCH1 = 4'd1;
    localparam logic [PROM_DW-1:0] ACT_LATCH2 = 4'd2;
    localparam logic [PROM_DW-1:0] ACT_LATCH3 = 4'd3;
    localparam logic [PROM_DW-1:0] ACT_OPLD   = 4'd4;
    localparam logic [PROM_DW-1:0] ACT_DRAW   = 4'd5;
    localparam logic [PROM_DW-1:0] ACT_JMP    = 4'd6;
    localparam logic [PROM_DW-1:0] ACT_HALT   = 4'd7;

    typedef enum logic [2:0] {
        FSM_HALT,
        FSM_ADDR,
        FSM_LOOK,
        FSM_EXEC,
        FSM_MEM,
        FSM_DRAWW
    } avg_fsm_e;

endpackage

// File: rtl/avg_latch_bank.sv
// Four program-byte latches feeding the vector timer/DAC word, the jump
// target and the opcode field.
module avg_latch_bank
    import avg_pkg::*;
#(
    parameter int PC_W = 13
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ld,
    input  logic [1:0]      idx,
    input  logic [7:0]      din,
    output logic [31:0]     vec_word,
    output logic [PC_W-1:0] jmp_tgt,
    output logic [2:0]      op_bits
);

    logic [7:0] lat [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) lat[i] <= '0;
        end else if (ld) begin
            lat[idx] <= din;
        end
    end

    assign vec_word = {lat[3], lat[2], lat[1], lat[0]};
    // Jump target is a word address; the cast fits it to the PC width.
    assign jmp_tgt  = PC_W'({lat[1][4:0], lat[0], 1'b0});
    assign op_bits  = lat[1][7:5];

endmodule

// File: rtl/avg_sequencer.sv
// Vector-generator sequencer: steps the external state PROM and executes
// the action each returned state encodes (latch, opcode, jump, draw, halt).
module avg_sequencer
    import avg_pkg::*;
#(
    parameter int PC_W = 13
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               vg_go,
    input  logic               vg_rst,
    input  logic [PC_W-1:0]    start_addr,
    output logic [PROM_AW-1:0] prom_addr,
    input  logic [PROM_DW-1:0] prom_data,
    output logic               vram_req,
    output logic [PC_W-1:0]    vram_addr,
    input  logic               vram_ack,
    input  logic [7:0]         vram_data,
    output logic               draw_go,
    input  logic               draw_done,
    output logic [31:0]        vec_word,
    output logic               halted
);

    avg_fsm_e           fsm, fsm_nxt;
    logic [PROM_DW-1:0] state;
    logic [2:0]         opcode;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    jmp_tgt;
    logic [2:0]         op_bits;

    logic go_start, ld_prom, ld_state, ld_op, do_jmp;
    logic req_set, mem_done, draw_set, halt_set;

    avg_latch_bank #(.PC_W(PC_W)) u_latch (
        .clk      (clk),
        .reset    (reset),
        .ld       (mem_done),
        .idx      (state[1:0]),
        .din      (vram_data),
        .vec_word (vec_word),
        .jmp_tgt  (jmp_tgt),
        .op_bits  (op_bits)
    );

    assign vram_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) fsm <= FSM_HALT;
        else       fsm <= fsm_nxt;
    end

    // vg_rst and vg_go bypass ce; everything else advances only when enabled.
    always_comb begin
        fsm_nxt  = fsm;
        go_start = 1'b0;
        ld_prom  = 1'b0;
        ld_state = 1'b0;
        ld_op    = 1'b0;
        do_jmp   = 1'b0;
        req_set  = 1'b0;
        mem_done = 1'b0;
        draw_set = 1'b0;
        halt_set = 1'b0;
        if (vg_rst) begin
            fsm_nxt = FSM_HALT;
        end else if (fsm == FSM_HALT) begin
            if (vg_go) begin
                go_start = 1'b1;
                fsm_nxt  = FSM_ADDR;
            end
        end else if (ce) begin
            case (fsm)
                FSM_ADDR: begin
                    ld_prom = 1'b1;
                    fsm_nxt = FSM_LOOK;
                end
                FSM_LOOK: begin
                    ld_state = 1'b1;
                    fsm_nxt  = FSM_EXEC;
                end
                FSM_EXEC: begin
                    case (state)
                        ACT_LATCH0, ACT_LATCH1, ACT_LATCH2, ACT_LATCH3: begin
                            req_set = 1'b1;
                            fsm_nxt = FSM_MEM;
                        end
                        ACT_OPLD: begin
                            ld_op   = 1'b1;
                            fsm_nxt = FSM_ADDR;
                        end
                        ACT_DRAW: begin
                            draw_set = 1'b1;
                            fsm_nxt  = FSM_DRAWW;
                        end
                        ACT_JMP: begin
                            do_jmp  = 1'b1;
                            fsm_nxt = FSM_ADDR;
                        end
                        ACT_HALT: begin
                            halt_set = 1'b1;
                            fsm_nxt  = FSM_HALT;
                        end
                        default: fsm_nxt = FSM_ADDR;
                    endcase
                end
                FSM_MEM: begin
                    if (vram_ack) begin
                        mem_done = 1'b1;
                        fsm_nxt  = FSM_ADDR;
                    end
                end
                // A done level seen during the pulse cycle belongs to the previous draw.
                FSM_DRAWW: begin
                    if (draw_done && !draw_go) fsm_nxt = FSM_ADDR;
                end
                default: fsm_nxt = FSM_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted    <= 1'b1;
            prom_addr <= 8'h80;
            pc        <= '0;
            state     <= '0;
            opcode    <= '0;
            vram_req  <= 1'b0;
            draw_go   <= 1'b0;
        end else begin
            draw_go <= draw_set;
            if (vg_rst) begin
                halted   <= 1'b1;
                vram_req <= 1'b0;
            end else begin
                if (go_start) begin
                    pc     <= start_addr;
                    halted <= 1'b0;
                    state  <= '0;
                    opcode <= '0;
                end
                if (ld_prom)  prom_addr <= {halted, opcode, state};
                if (ld_state) state     <= prom_data;
                if (ld_op)    opcode    <= op_bits;
                if (do_jmp)   pc        <= jmp_tgt;
                if (req_set)  vram_req  <= 1'b1;
                if (mem_done) begin
                    pc       <= pc + PC_W'(1);
                    vram_req <= 1'b0;
                end
                if (halt_set) halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_sequencer.sv
// Scoreboard bench for avg_sequencer: a sequenced PROM model, a program
// memory and a vector timer model surround the sequencer.
module tb_avg_sequencer;
    import avg_pkg::*;

    localparam int PC_W = 13;

    logic            clk = 1'b0;
    logic            reset, ce = 1'b1, vg_go, vg_rst;
    logic [PC_W-1:0] start_addr;
    logic [7:0]      prom_addr;
    logic [3:0]      prom_data;
    logic            vram_req;
    logic [PC_W-1:0] vram_addr;
    logic            vram_ack;
    logic [7:0]      vram_data;
    logic            draw_go, draw_done;
    logic [31:0]     vec_word;
    logic            halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PC_W-1:0] exp_addr_q[$];
    logic [31:0]     exp_vec_q[$];

    logic [7:0] mem [2**PC_W];
    logic [3:0] seq [16];
    int seq_len = 0, looks = 0, base = 0, pidx;
    int en_cnt = 0, cyc = 0;
    bit ce_slow = 0, mem_auto = 1, draw_auto = 1;
    logic mem_ack = 1'b0, frc_ack = 1'b0;
    logic [7:0] mem_dat = '0, frc_data = '0;
    int wcnt = 0, ack_dly = 0;
    logic dd_auto = 1'b0, dd_man = 1'b0;
    int dcnt = 0, draw_dly = 0;
    bit dbusy = 0;
    int draw_cnt = 0, gw = 0;
    logic req_prev = 1'b0;

    avg_sequencer #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .vg_go      (vg_go),
        .vg_rst     (vg_rst),
        .start_addr (start_addr),
        .prom_addr  (prom_addr),
        .prom_data  (prom_data),
        .vram_req   (vram_req),
        .vram_addr  (vram_addr),
        .vram_ack   (vram_ack),
        .vram_data  (vram_data),
        .draw_go    (draw_go),
        .draw_done  (draw_done),
        .vec_word   (vec_word),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Clock enable: always on, or one cycle in four.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        ce  <= !ce_slow || (cyc % 4 == 0);
    end
    always @(posedge clk) if (ce) en_cnt <= en_cnt + 1;

    // PROM model returns the programmed state sequence, one entry per lookup.
    always @(posedge clk) if (ce && dut.fsm == FSM_LOOK) looks <= looks + 1;
    always_comb begin
        pidx      = looks - base;
        prom_data = ACT_HALT;
        if (pidx >= 0 && pidx < seq_len) prom_data = seq[pidx[3:0]];
    end

    // Program memory: ack after ack_dly cycles, held until the request drops.
    always @(negedge clk) begin
        if (!mem_auto || !vram_req) begin
            mem_ack <= 1'b0;
            wcnt    <= 0;
        end else if (!mem_ack) begin
            if (wcnt >= ack_dly) begin
                mem_ack <= 1'b1;
                mem_dat <= mem[vram_addr];
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end
    assign vram_ack  = mem_ack | frc_ack;
    assign vram_data = frc_ack ? frc_data : mem_dat;

    // Vector timer: done level rises draw_dly cycles after the pulse.
    always @(negedge clk) begin
        if (draw_go) begin
            dd_auto <= 1'b0;
            dbusy   <= 1'b1;
            dcnt    <= 0;
        end else if (dbusy) begin
            if (dcnt >= draw_dly) begin
                dd_auto <= 1'b1;
                dbusy   <= 1'b0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end
    assign draw_done = draw_auto ? dd_auto : dd_man;

    // Scoreboard: each new request and each draw pulse pops an expectation.
    always @(negedge clk) begin
        if (vram_req && !req_prev) begin
            if (exp_addr_q.size() == 0) chk("unexpected_req", 32'(vram_addr), 32'hFFFF_FFFF);
            else                        chk("req_addr", 32'(vram_addr), 32'(exp_addr_q.pop_front()));
        end
        req_prev <= vram_req;
        if (draw_go) begin
            draw_cnt <= draw_cnt + 1;
            gw       <= gw + 1;
            if (exp_vec_q.size() == 0) chk("unexpected_draw", vec_word, 32'hFFFF_FFFF);
            else                       chk("draw_vec", vec_word, exp_vec_q.pop_front());
        end else if (gw != 0) begin
            chk("draw_go_width", 32'(gw), 32'd1);
            gw <= 0;
        end
    end

    task automatic set_seq(input logic [23:0] s, input int n);
        for (int i = 0; i < n; i++) seq[i] = s[4*i +: 4];
        seq_len = n;
        base    = looks;
    endtask

    task automatic go(input logic [PC_W-1:0] a);
        start_addr = a;
        vg_go      = 1'b1;
        @(negedge clk);
        vg_go      = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max);
        int k = 0;
        while (!halted && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, d0, l0, e0, k;
        reset = 1'b1; vg_go = 1'b0; vg_rst = 1'b0; start_addr = '0;
        for (int i = 0; i < 2**PC_W; i++) mem[i] = 8'(i);
        mem[13'h0010] = 8'hAA; mem[13'h0011] = 8'hBB;
        mem[13'h0012] = 8'hCC; mem[13'h0013] = 8'hDD;
        mem[13'h0100] = 8'h34; mem[13'h0101] = 8'hE2;
        mem[13'h0468] = 8'h55; mem[13'h1FFF] = 8'h5A;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values and idle behaviour
        chk("rst_prom_addr", 32'(prom_addr), 32'h80);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_vram_req", 32'(vram_req), 32'd0);
        chk("rst_draw_go", 32'(draw_go), 32'd0);
        chk("rst_vec_word", vec_word, 32'd0);
        chk("rst_pc", 32'(vram_addr), 32'd0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (vram_req) seen++;
        end
        chk("idle_req_cycles", 32'(seen), 32'd0);
        chk("idle_prom_addr", 32'(prom_addr), 32'h80);

        // Four latches then a draw, then halt
        set_seq({4'd7, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0}, 6);
        exp_addr_q.push_back(13'h0010); exp_addr_q.push_back(13'h0011);
        exp_addr_q.push_back(13'h0012); exp_addr_q.push_back(13'h0013);
        exp_vec_q.push_back(32'hDDCCBBAA);
        d0 = draw_cnt;
        go(13'h0010);
        chk("halted_fall", 32'(halted), 32'd0);
        wait_halt("t2_halt", 400);
        chk("t2_pc", 32'(vram_addr), 32'h0014);
        chk("t2_draws", 32'(draw_cnt - d0), 32'd1);
        chk("t2_vec", vec_word, 32'hDDCCBBAA);

        // Opcode load and jump
        set_seq({4'd7, 4'd0, 4'd6, 4'd4, 4'd1, 4'd0}, 6);
        exp_addr_q.push_back(13'h0100); exp_addr_q.push_back(13'h0101);
        exp_addr_q.push_back(13'h0468);
        go(13'h0100);
        wait_halt("t3_halt", 400);
        chk("t3_pc", 32'(vram_addr), 32'h0469);
        chk("t3_prom_opcode", 32'(prom_addr), 32'h70);
        chk("t3_vec", vec_word, 32'hDDCCE255);

        // vg_rst while waiting on memory; late ack ignored
        mem_auto = 0;
        set_seq({4'd7, 4'd2}, 2);
        exp_addr_q.push_back(13'h0200);
        go(13'h0200);
        k = 0;
        while (!vram_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t4_req", 32'(vram_req), 32'd1);
        chk("t4_prom_op_clr", 32'(prom_addr), 32'h00);
        repeat (2) @(negedge clk);
        vg_rst = 1'b1;
        @(negedge clk);
        vg_rst = 1'b0;
        chk("t4_req_drop", 32'(vram_req), 32'd0);
        chk("t4_halted", 32'(halted), 32'd1);
        repeat (2) @(negedge clk);
        frc_data = 8'h99;
        frc_ack  = 1'b1;
        repeat (3) @(negedge clk);
        frc_ack  = 1'b0;
        @(negedge clk);
        chk("t4_late_ack_vec", vec_word, 32'hDDCCE255);
        chk("t4_late_ack_pc", 32'(vram_addr), 32'h0200);
        chk("t4_late_ack_req", 32'(vram_req), 32'd0);
        l0 = looks;
        start_addr = 13'h0555;
        vg_go  = 1'b1;
        vg_rst = 1'b1;
        @(negedge clk);
        vg_go  = 1'b0;
        vg_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_rst_wins_halted", 32'(halted), 32'd1);
        chk("t4_rst_wins_looks", 32'(looks - l0), 32'd0);
        chk("t4_rst_wins_pc", 32'(vram_addr), 32'h0200);
        mem_auto = 1;

        // Slow ce with draw_done held low
        draw_auto = 0;
        dd_man    = 1'b0;
        ce_slow   = 1;
        set_seq({4'd7, 4'd5}, 2);
        exp_vec_q.push_back(32'hDDCCE255);
        d0 = draw_cnt;
        go(13'h0300);
        k = 0;
        while (draw_cnt == d0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_draw_seen", 32'(draw_cnt - d0), 32'd1);
        l0 = looks;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                start_addr = 13'h0777;
                vg_go = 1'b1;
            end else begin
                vg_go = 1'b0;
            end
            @(negedge clk);
            if (halted) seen++;
        end
        vg_go = 1'b0;
        chk("t5_hold_halted", 32'(seen), 32'd0);
        chk("t5_hold_looks", 32'(looks - l0), 32'd0);
        dd_man = 1'b1;
        e0 = en_cnt;
        wait_halt("t5_halt", 200);
        chk("t5_enabled_edges", 32'(en_cnt - e0), 32'd4);
        chk("t5_one_lookup", 32'(looks - l0), 32'd1);
        chk("t5_go_ignored_pc", 32'(vram_addr), 32'h0300);
        ce_slow   = 0;
        dd_man    = 1'b0;
        draw_auto = 1;
        repeat (2) @(negedge clk);

        // Program counter wrap
        set_seq({4'd7, 4'd0}, 2);
        exp_addr_q.push_back(13'h1FFF);
        go(13'h1FFF);
        wait_halt("t6_halt", 200);
        chk("t6_pc_wrap", 32'(vram_addr), 32'h0000);
        chk("t6_vec", vec_word, 32'hDDCCE25A);

        repeat (3) @(negedge clk);
        chk("sb_addr_left", 32'(exp_addr_q.size()), 32'd0);
        chk("sb_vec_left", 32'(exp_vec_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_sequencer.md
# avg_sequencer

Vector-generator sequencer that walks the 256x4 state PROM and drives the vector program fetch. Each micro-step presents `{halted, opcode, state}` to the PROM and loads the returned nibble as the next state. It then executes the action that state encodes: latch a program byte, load the opcode, jump, start a draw, or halt. It sits between the CPU vector-go/reset strobes, vector RAM/ROM, the state PROM and the vector timer/DAC stage.

## Interface
- `PC_W`, default 13: vector program counter width, in bytes.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; the FSM advances only when `ce`=1.
- `vg_go`  in  1  one-cycle strobe: start execution at `start_addr`.
- `vg_rst`  in  1  one-cycle strobe: force the halted state.
- `start_addr`  in  PC_W  program start byte address.
- `prom_addr`  out  8  state PROM address, registered.
- `prom_data`  in  4  PROM output, valid one clock after `prom_addr` changes.
- `vram_req`  out  1  memory read request; held until ack.
- `vram_addr`  out  PC_W  read address; equals `pc`.
- `vram_ack`  in  1  read complete; `vram_data` is valid in the same cycle.
- `vram_data`  in  8  program byte.
- `draw_go`  out  1  one-cycle pulse: vector parameters are valid.
- `draw_done`  in  1  vector timer finished.
- `vec_word`  out  32  `{latch3, latch2, latch1, latch0}` to the timer/DAC.
- `halted`  out  1  sequencer idle.

## Operation
- Four-bit state actions, with constants in the package:
  - 0–3: LATCHn. Read the byte at `pc`, load it into latch n, then `pc`+1.
  - 4: OPLD. `opcode`←`latch1[7:5]`.
  - 5: DRAW. Pulse `draw_go`, then wait for `draw_done`.
  - 6: JMP. `pc`←`{latch1[4:0], latch0, 1'b0}[PC_W-1:0]`.
  - 7: HALT. Set `halted`.
  - 8–15: no action.
- FSM states: HALT, ADDR, LOOK, EXEC, MEM, DRAWW. Every transition is gated by `ce`, except that `vg_rst`/`vg_go`/`reset` act unconditionally.
- HALT:
  - On `vg_go`: `pc`←`start_addr`, `halted`←0, `state`←0, `opcode`←0, go to ADDR.
- ADDR:
  - `prom_addr`←`{halted, opcode, state}`, go to LOOK.
- LOOK:
  - `state`←`prom_data`, go to EXEC.
- EXEC:
  - Decode `state`.
  - LATCHn: assert `vram_req`, go to MEM.
  - DRAW: pulse `draw_go`, go to DRAWW.
  - HALT action: `halted`←1, go to HALT.
  - All others: execute in one cycle, go to ADDR.
- MEM:
  - On `vram_ack`: latch the byte, `pc`+1 mod 2^PC_W, drop `vram_req`, go to ADDR.
- DRAWW:
  - On `draw_done`, go to ADDR.
  - If `draw_done` is already high in the cycle after the pulse, that counts as done.
- `vg_rst` in any state: go to HALT, `halted`←1, drop `vram_req`, no `draw_go`. Latches and `pc` are kept.
- `vg_go` while not halted: ignored.
- `vg_go` and `vg_rst` in the same cycle: `vg_rst` wins.
- `pc` wraps from `2^PC_W-1` to 0 silently.

## Timing
- Reset values:
  - FSM=HALT, `halted`=1, `prom_addr`=0x80, `pc`=0.
  - All latches 0, `opcode`=0, `state`=0.
  - `vram_req`=0, `draw_go`=0, `vec_word`=0.
- Non-memory micro-step: 3 enabled cycles (ADDR, LOOK, EXEC).
- LATCH micro-step: 4 enabled cycles plus memory wait. `vram_req` rises on the EXEC edge.
- `draw_go` is high for exactly one `clk` cycle. `vec_word` is stable from that cycle until the next LATCH.
- `ce`=0 in MEM: `vram_req` stays asserted. An ack during `ce`=0 is lost, so the memory must hold ack until it is sampled with `ce`=1.
- `halted` falls on the cycle after `vg_go` and rises on the EXEC cycle of a HALT action.

## Structure
- `avg_pkg`:
  - action constants `ACT_LATCH0..ACT_HALT`;
  - FSM state enum;
  - `PROM_AW`=8, `PROM_DW`=4.
- Sub-module `avg_latch_bank`: four 8-bit latches with load strobe and index; outputs `vec_word` and the jump target.
- The sequencer instantiates the existing state PROM externally. The PROM is not embedded.

## Test plan
- Reset then idle: `prom_addr`=0x80, `halted`=1, no `vram_req` for 100 cycles.
- `vg_go` with `start_addr`=0x0010, PROM model returns 0,1,2,3,5, memory bytes AA,BB,CC,DD: one `draw_go`, `vec_word`=0xDDCCBBAA, `pc`=0x0014.
- JMP: latch0=0x34, latch1=0x02, state 6: `pc`=0x0468, next `vram_addr`=0x0468.
- `vg_rst` asserted in MEM with ack delayed 5 cycles: `vram_req` drops next cycle, `halted`=1, late ack ignored.
- `ce` toggling 1-of-4 and `draw_done` held low 20 cycles: FSM holds in DRAWW, resumes exactly one ADDR after `draw_done`.
- `pc`=0x1FFF, LATCH0: byte loaded, `pc` wraps to 0x0000.
